// File: rtl/fp_pkg.sv
// Shared floating-point definitions: flag indices, operand classes, format helpers.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package fp_pkg;

  // Bit positions inside the 5-bit status vector {nan, inf, zero, overflow, underflow}
  localparam int FLG_UDF = 0;
  localparam int FLG_OVF = 1;
  localparam int FLG_ZER = 2;
  localparam int FLG_INF = 3;
  localparam int FLG_NAN = 4;
  localparam int FLG_W   = 5;

  // Operand classification; subnormals are folded into CLS_ZERO
  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  // Exponent bias for an exp_w-bit exponent field
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, 0...}, right-aligned in 64 bits
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier.
// Wires only, no latency.
// in_ready/out_ready carry back-pressure in each direction.
interface fp_mult_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();

  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     OperandA;
  logic [W-1:0]     OperandB;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic [FLG_W-1:0] flags;

  // Producer/consumer side (operand fetch + accumulator)
  modport master (
    output in_valid, OperandA, OperandB, out_ready,
    input  in_ready, out_valid, out, flags
  );

  // Multiplier side
  modport slave (
    input  in_valid, OperandA, OperandB, out_ready,
    output in_ready, out_valid, out, flags
  );

endinterface

// File: rtl/fp_round_norm.sv
// Normalise a raw significand product, round to nearest-even, detect exponent range limits.
// Purely combinational, zero latency.
// No handshake; the caller registers the outputs.
module fp_round_norm
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]       prod_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  output logic [EXP_W-1:0]         exp_o,
  output logic [MAN_W-1:0]         man_o,
  output logic                     ovf_o,
  output logic                     udf_o
);

  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ZERO_X = '0;

  logic                 norm;
  logic [PW-2:0]        sh;
  logic [MAN_W-1:0]     mant;
  logic                 g_bit;
  logic                 r_bit;
  logic                 s_bit;
  logic                 rnd_up;
  logic                 carry;
  logic [MAN_W-1:0]     mant_r;
  logic signed [XW-1:0] e;

  // Align hidden bit to the top, then RNE on guard/round/sticky; a rounding
  // carry leaves mant_r at zero, which is already the renormalised 1.000 value
  always_comb begin
    norm   = prod_i[PW-1];
    sh     = norm ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
    mant   = sh[PW-2 -: MAN_W];
    g_bit  = sh[PW-2-MAN_W];
    r_bit  = sh[PW-3-MAN_W];
    s_bit  = |sh[PW-4-MAN_W:0];
    rnd_up = g_bit & (r_bit | s_bit | mant[0]);
    {carry, mant_r} = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
    e      = exp_i + $signed({{(XW-1){1'b0}}, norm}) + $signed({{(XW-1){1'b0}}, carry});
    ovf_o  = (e >= EMAX_X);
    udf_o  = (e <= ZERO_X);
    exp_o  = e[EXP_W-1:0];
    man_o  = mant_r;
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-style FP multiplier, RNE rounding, flush-to-zero, per-result status flags.
// Fixed 3-cycle latency, one result per cycle when unstalled.
// Global stall: every stage freezes while a result waits unaccepted; in_ready = ~out_valid | out_ready.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic          clk,
  input  logic          rst,
  fp_mult_pipe_if.slave bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [XW-1:0] BIAS_X   = XW'(fp_bias(EXP_W));
  localparam logic [63:0]          QNAN64   = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN     = QNAN64[W-1:0];

  logic en;

  // stage 1 state
  logic                 s1_vld_q;
  fp_cls_e              s1_cls_a_q, s1_cls_b_q;
  logic                 s1_sign_q;
  logic signed [XW-1:0] s1_exp_q;
  logic [SW-1:0]        s1_sig_a_q, s1_sig_b_q;

  // stage 2 state
  logic                 s2_vld_q;
  fp_cls_e              s2_cls_a_q, s2_cls_b_q;
  logic                 s2_sign_q;
  logic signed [XW-1:0] s2_exp_q;
  logic [PW-1:0]        s2_prod_q;

  // stage 3 (output) state
  logic                 out_valid_q;
  logic [W-1:0]         out_q;
  logic [FLG_W-1:0]     flags_q;

  // stage 1 next-state
  logic [EXP_W-1:0]     exp_a, exp_b;
  logic [MAN_W-1:0]     man_a, man_b;
  fp_cls_e              cls_a_d, cls_b_d;
  logic                 sign_d;
  logic signed [XW-1:0] exp_sum_d;
  logic [SW-1:0]        sig_a_d, sig_b_d;

  // stage 2 / 3 next-state
  logic [PW-1:0]        prod_d;
  logic [EXP_W-1:0]     rn_exp;
  logic [MAN_W-1:0]     rn_man;
  logic                 rn_ovf, rn_udf;
  logic                 any_nan, any_inf, any_zero;
  logic [W-1:0]         out_d;
  logic [FLG_W-1:0]     flags_d;

  assign en            = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

  assign exp_a = bus.OperandA[W-2 -: EXP_W];
  assign exp_b = bus.OperandB[W-2 -: EXP_W];
  assign man_a = bus.OperandA[MAN_W-1:0];
  assign man_b = bus.OperandB[MAN_W-1:0];

  // Classify operands, form product sign, biased exponent sum and significands
  always_comb begin
    cls_a_d = CLS_NORM;
    if (exp_a == '0)
      cls_a_d = CLS_ZERO;
    else if (exp_a == EXP_ONES)
      cls_a_d = (man_a == '0) ? CLS_INF : CLS_NAN;
    cls_b_d = CLS_NORM;
    if (exp_b == '0)
      cls_b_d = CLS_ZERO;
    else if (exp_b == EXP_ONES)
      cls_b_d = (man_b == '0) ? CLS_INF : CLS_NAN;
    sign_d    = bus.OperandA[W-1] ^ bus.OperandB[W-1];
    exp_sum_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_X;
    sig_a_d   = {1'b1, man_a};
    sig_b_d   = {1'b1, man_b};
  end

  // Stage 1 register: captures one operand pair (or a bubble) per enabled cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q   <= 1'b0;
      s1_cls_a_q <= CLS_ZERO;
      s1_cls_b_q <= CLS_ZERO;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_sig_a_q <= '0;
      s1_sig_b_q <= '0;
    end else if (en) begin
      s1_vld_q   <= bus.in_valid;
      s1_cls_a_q <= cls_a_d;
      s1_cls_b_q <= cls_b_d;
      s1_sign_q  <= sign_d;
      s1_exp_q   <= exp_sum_d;
      s1_sig_a_q <= sig_a_d;
      s1_sig_b_q <= sig_b_d;
    end
  end

  assign prod_d = {{SW{1'b0}}, s1_sig_a_q} * {{SW{1'b0}}, s1_sig_b_q};

  // Stage 2 register: full-width significand product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q   <= 1'b0;
      s2_cls_a_q <= CLS_ZERO;
      s2_cls_b_q <= CLS_ZERO;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_prod_q  <= '0;
    end else if (en) begin
      s2_vld_q   <= s1_vld_q;
      s2_cls_a_q <= s1_cls_a_q;
      s2_cls_b_q <= s1_cls_b_q;
      s2_sign_q  <= s1_sign_q;
      s2_exp_q   <= s1_exp_q;
      s2_prod_q  <= prod_d;
    end
  end

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_norm (
    .prod_i (s2_prod_q),
    .exp_i  (s2_exp_q),
    .exp_o  (rn_exp),
    .man_o  (rn_man),
    .ovf_o  (rn_ovf),
    .udf_o  (rn_udf)
  );

  // Special cases override the arithmetic path: NaN, then inf, then zero, then range limits
  always_comb begin
    out_d    = '0;
    flags_d  = '0;
    any_nan  = (s2_cls_a_q == CLS_NAN)  | (s2_cls_b_q == CLS_NAN);
    any_inf  = (s2_cls_a_q == CLS_INF)  | (s2_cls_b_q == CLS_INF);
    any_zero = (s2_cls_a_q == CLS_ZERO) | (s2_cls_b_q == CLS_ZERO);
    if (any_nan || (any_zero && any_inf)) begin
      out_d            = QNAN;
      flags_d[FLG_NAN] = 1'b1;
    end else if (any_inf) begin
      out_d            = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d[FLG_INF] = 1'b1;
    end else if (any_zero) begin
      out_d            = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
      flags_d[FLG_ZER] = 1'b1;
    end else if (rn_ovf) begin
      out_d            = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d[FLG_INF] = 1'b1;
      flags_d[FLG_OVF] = 1'b1;
    end else if (rn_udf) begin
      out_d            = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
      flags_d[FLG_ZER] = 1'b1;
      flags_d[FLG_UDF] = 1'b1;
    end else begin
      out_d            = {s2_sign_q, rn_exp, rn_man};
    end
  end

  // Stage 3 register: result and flags, held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= s2_vld_q;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench: integer-arithmetic reference model plus directed literal vectors.
// Single-precision DUT is scoreboarded every cycle; half-precision DUT checked per vector.
// Covers latency, specials, range limits, back-pressure, random traffic and mid-stream reset.
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) sp ();
  fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) hp ();

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut_sp (.clk(clk), .rst(rst), .bus(sp.slave));
  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_hp (.clk(clk), .rst(rst), .bus(hp.slave));

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
  } exp_t;

  exp_t        sb[$];
  exp_t        ex_v;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out;
  logic [4:0]  prev_flags;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: exact integer product, rounded to nearest-even by remainder comparison
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input int E, input int M,
                                output logic [31:0] r, output logic [4:0] f);
    longint one, emax, bias, ea, eb, ma, mb, p, q, rem, half, e, sgn;
    int     k, sh;
    bit     na, nb, ia, ib, za, zb;
    one  = 1;
    emax = (one << E) - 1;
    bias = (one << (E - 1)) - 1;
    ea   = (longint'(a) >> M) & emax;
    eb   = (longint'(b) >> M) & emax;
    ma   = longint'(a) & ((one << M) - 1);
    mb   = longint'(b) & ((one << M) - 1);
    sgn  = longint'(a[E+M] ^ b[E+M]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == emax) && (ma == 0);
    ib = (eb == emax) && (mb == 0);
    na = (ea == emax) && (ma != 0);
    nb = (eb == emax) && (mb != 0);
    r = '0;
    f = '0;
    if (na || nb || (za && ib) || (zb && ia)) begin
      r = 32'((emax << M) | (one << (M - 1)));
      f = 5'b10000;
    end else if (ia || ib) begin
      r = 32'((sgn << (E + M)) | (emax << M));
      f = 5'b01000;
    end else if (za || zb) begin
      r = 32'(sgn << (E + M));
      f = 5'b00100;
    end else begin
      p  = (ma + (one << M)) * (mb + (one << M));
      k  = (p >= (one << (2 * M + 1))) ? 2 * M + 1 : 2 * M;
      sh = k - M;
      q    = p >> sh;
      rem  = p & ((one << sh) - 1);
      half = one << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == (one << (M + 1))) begin
        q = q >> 1;
        k = k + 1;
      end
      e = ea + eb - bias + longint'(k - 2 * M);
      if (e >= emax) begin
        r = 32'((sgn << (E + M)) | (emax << M));
        f = 5'b01010;
      end else if (e <= 0) begin
        r = 32'(sgn << (E + M));
        f = 5'b00101;
      end else begin
        r = 32'((sgn << (E + M)) | (e << M) | (q - (one << M)));
      end
    end
  endfunction

  // Single-precision scoreboard and protocol checks, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", 64'(sp.in_ready), 64'(!sp.out_valid || sp.out_ready));
      if (prev_stall) begin
        chk("hold_valid", 64'(sp.out_valid), 64'(1));
        chk("hold_data", 64'({sp.flags, sp.out}), 64'({prev_flags, prev_out}));
      end
      if (sp.in_valid && sp.in_ready) begin
        model(sp.OperandA, sp.OperandB, 8, 23, ex_v.r, ex_v.f);
        sb.push_back(ex_v);
      end
      if (sp.out_valid && sp.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 64'(sp.out_valid), 64'(0));
        end else begin
          ex_v = sb.pop_front();
          chk("sb_out", 64'(sp.out), 64'(ex_v.r));
          chk("sb_flags", 64'(sp.flags), 64'(ex_v.f));
          n_out++;
        end
      end
      prev_stall = sp.out_valid && !sp.out_ready;
      prev_out   = sp.out;
      prev_flags = sp.flags;
    end
  end

  task automatic single_sp(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [4:0] ef);
    logic [31:0] mr;
    logic [4:0]  mf;
    int          waitc;
    model(a, b, 8, 23, mr, mf);
    chk({nm, "_model_out"}, 64'(mr), 64'(er));
    chk({nm, "_model_flags"}, 64'(mf), 64'(ef));
    @(posedge clk); #1;
    sp.in_valid = 1'b1; sp.OperandA = a; sp.OperandB = b; sp.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_accept"}, 64'(sp.in_ready), 64'(1));
    @(posedge clk); #1;
    sp.in_valid = 1'b0;
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!sp.out_valid && waitc < 20);
    chk({nm, "_latency"}, 64'(waitc), 64'(3));
    chk({nm, "_dut_out"}, 64'(sp.out), 64'(er));
    chk({nm, "_dut_flags"}, 64'(sp.flags), 64'(ef));
  endtask

  task automatic single_hp(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic [4:0] ef);
    logic [31:0] mr;
    logic [4:0]  mf;
    int          waitc;
    model({16'h0, a}, {16'h0, b}, 5, 10, mr, mf);
    chk({nm, "_model_out"}, 64'(mr), 64'(er));
    chk({nm, "_model_flags"}, 64'(mf), 64'(ef));
    @(posedge clk); #1;
    hp.in_valid = 1'b1; hp.OperandA = a; hp.OperandB = b; hp.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    hp.in_valid = 1'b0;
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!hp.out_valid && waitc < 20);
    chk({nm, "_latency"}, 64'(waitc), 64'(3));
    chk({nm, "_dut_out"}, 64'(hp.out), 64'(er));
    chk({nm, "_dut_flags"}, 64'(hp.flags), 64'(ef));
  endtask

  task automatic backpressure_stream();
    logic [31:0] va[10];
    logic [31:0] vb[10];
    int i, c, n0;
    for (int j = 0; j < 10; j++) begin
      va[j] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom())};
      vb[j] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom())};
    end
    n0 = n_out;
    i = 0;
    c = 0;
    while ((i < 10 || (n_out - n0) < 10) && c < 100) begin
      @(posedge clk); #1;
      sp.out_ready = !(c >= 4 && c <= 8);
      sp.in_valid  = (i < 10);
      if (i < 10) begin
        sp.OperandA = va[i];
        sp.OperandB = vb[i];
      end
      @(negedge clk);
      if (sp.in_valid && sp.in_ready) i++;
      c++;
    end
    @(posedge clk); #1;
    sp.in_valid  = 1'b0;
    sp.out_ready = 1'b1;
    chk("bp_sent", 64'(i), 64'(10));
    chk("bp_received", 64'(n_out - n0), 64'(10));
  endtask

  task automatic random_stream();
    int  sent, c;
    bit  hold;
    sent = 0;
    c    = 0;
    hold = 1'b0;
    while (sent < 40 && c < 400) begin
      @(posedge clk); #1;
      sp.out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        sp.in_valid = ($urandom_range(0, 4) != 0);
        sp.OperandA = $urandom();
        sp.OperandB = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 170)), 23'($urandom())};
      end
      @(negedge clk);
      hold = sp.in_valid && !sp.in_ready;
      if (sp.in_valid && sp.in_ready) sent++;
      c++;
    end
    @(posedge clk); #1;
    sp.in_valid  = 1'b0;
    sp.out_ready = 1'b1;
    c = 0;
    while (sb.size() != 0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rand_sent", 64'(sent), 64'(40));
    chk("rand_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic reset_midstream();
    sp.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      sp.in_valid = 1'b1;
      sp.OperandA = 32'h3FC00000 + 32'(j);
      sp.OperandB = 32'h40000000;
      @(negedge clk);
    end
    @(posedge clk); #1;
    sp.in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(sp.out_valid), 64'(1));
    rst = 1'b0;
    #1;
    chk("rst_valid_drop", 64'(sp.out_valid), 64'(0));
    chk("rst_in_ready", 64'(sp.in_ready), 64'(1));
    chk("rst_out_zero", 64'(sp.out), 64'(0));
    chk("rst_flags_zero", 64'(sp.flags), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(sp.out_valid), 64'(0));
    end
  endtask

  initial begin
    sp.in_valid = 1'b0; sp.OperandA = '0; sp.OperandB = '0; sp.out_ready = 1'b1;
    hp.in_valid = 1'b0; hp.OperandA = '0; hp.OperandB = '0; hp.out_ready = 1'b1;
    #2;
    chk("reset_sp_out_valid", 64'(sp.out_valid), 64'(0));
    chk("reset_sp_in_ready", 64'(sp.in_ready), 64'(1));
    chk("reset_sp_out", 64'(sp.out), 64'(0));
    chk("reset_sp_flags", 64'(sp.flags), 64'(0));
    chk("reset_hp_out_valid", 64'(hp.out_valid), 64'(0));
    chk("reset_hp_in_ready", 64'(hp.in_ready), 64'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    single_sp("mul_1p5x2",    32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000);
    single_sp("mul_ulp",      32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00000);
    single_sp("mul_maxsig",   32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 5'b00000);
    single_sp("mul_neg",      32'hC0000000, 32'h3FC00000, 32'hC0400000, 5'b00000);
    single_sp("mul_inf",      32'h40400000, 32'hFF800000, 32'hFF800000, 5'b01000);
    single_sp("mul_zero_inf", 32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b10000);
    single_sp("mul_subnorm",  32'h00400000, 32'h40000000, 32'h00000000, 5'b00100);
    single_sp("mul_overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b01010);
    single_sp("mul_underflow",32'h00800000, 32'h00800000, 32'h00000000, 5'b00101);

    single_hp("hp_1p5x2",     16'h3E00, 16'h4000, 16'h4200, 5'b00000);
    single_hp("hp_overflow",  16'h7BFF, 16'h7BFF, 16'h7C00, 5'b01010);
    single_hp("hp_rnd_carry", 16'h3DA8, 16'h3DA8, 16'h4000, 5'b00000);
    single_hp("hp_tie_up",    16'h3C01, 16'h3E00, 16'h3E02, 5'b00000);
    single_hp("hp_tie_even",  16'h3C03, 16'h3E00, 16'h3E04, 5'b00000);

    backpressure_stream();
    random_stream();
    reset_midstream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
